// File: rtl/alu_seq.sv
// Execute-stage ALU with valid/ready handshakes: single-cycle add/sub/shift/logic
// and a WIDTH-cycle shift-add unsigned multiply producing a 2*WIDTH product.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         alu_op,
  input  logic [WIDTH-1:0]   top_operand,
  input  logic [WIDTH-1:0]   bottom_operand,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         alu_flags,
  output logic [2*WIDTH-1:0] alu_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_SHL = 3'd3,
    OP_SHR = 3'd4, OP_AND = 3'd5, OP_OR  = 3'd6, OP_XOR = 3'd7
  } op_e;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   out_q, out_d;
  logic [2:0]           flags_q, flags_d;
  logic                 out_valid_q, out_valid_d;

  // Single-cycle datapath, evaluated on the live inputs at accept time.
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     sc_res;
  logic                 sc_c;
  logic [2*WIDTH-1:0]   partial;
  logic                 accept;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign alu_out   = out_q;
  assign alu_flags = flags_q;

  assign sum     = {1'b0, top_operand} + {1'b0, bottom_operand};
  assign partial = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    case (op_e'(alu_op))
      OP_ADD: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
      end
      OP_SUB: begin
        sc_res = top_operand - bottom_operand;
        sc_c   = top_operand < bottom_operand;
      end
      OP_SHL: begin
        sc_res = {top_operand[WIDTH-2:0], 1'b0};
        sc_c   = top_operand[WIDTH-1];
      end
      OP_SHR: begin
        sc_res = {1'b0, top_operand[WIDTH-1:1]};
        sc_c   = top_operand[0];
      end
      OP_AND:  sc_res = top_operand & bottom_operand;
      OP_OR:   sc_res = top_operand | bottom_operand;
      OP_XOR:  sc_res = top_operand ^ bottom_operand;
      default: sc_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;

    case (state_q)
      MUL: begin
        acc_d    = partial;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          out_d       = partial;
          flags_d     = {partial[2*WIDTH-1], |partial[2*WIDTH-1:WIDTH], partial == '0};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        // Consumed with nothing new waiting: release the output.
        if (out_ready && !in_valid) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: ;
    endcase

    // IDLE, or DONE being drained, takes a new request exactly like IDLE would.
    if (accept) begin
      if (op_e'(alu_op) == OP_MUL) begin
        acc_d       = '0;
        mcand_d     = {{WIDTH{1'b0}}, top_operand};
        mplier_d    = bottom_operand;
        cnt_d       = CW'(WIDTH);
        out_valid_d = 1'b0;
        state_d     = MUL;
      end else begin
        out_d       = {{WIDTH{1'b0}}, sc_res};
        flags_d     = {sc_res[WIDTH-1], sc_c, sc_res == '0};
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the execute-stage ALU. It performs eight operations at a configurable operand width: add, subtract, unsigned multiply, shift left, shift right, AND, OR and XOR. All operations except multiply complete in one cycle. Multiply is a sequential shift-add that takes WIDTH cycles. It sits in the execute stage between operand fetch and writeback, and uses valid/ready handshakes on both sides so the pipeline can stall around multi-cycle multiplies.

## Interface
Parameters:
- WIDTH, 8: operand width in bits, minimum 2. The result is 2*WIDTH bits.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- alu_op  in  3  0 add, 1 sub, 2 mul, 3 shl, 4 shr, 5 and, 6 or, 7 xor
- top_operand  in  WIDTH  first operand
- bottom_operand  in  WIDTH  second operand; ignored by shl and shr
- out_valid  out  1  result and flags are valid
- out_ready  in  1  consumer accepts the result
- alu_flags  out  3  {N, C, Z}
- alu_out  out  2*WIDTH  result

## Operation
- **States:** IDLE, MUL, DONE.
- **Accept rule:** a request is accepted on a rising edge where in_valid && in_ready. Operands and alu_op are captured at that edge and the inputs are not sampled again.
- **in_ready:** high in IDLE, and high in DONE when out_ready is high. It is low in MUL and in DONE while out_ready is low.
- **Single-cycle op accepted:**
  - compute, register the result into alu_out and alu_flags, and go to DONE.
  - alu_out[2W-1:W] = 0 for all single-cycle ops.
- **Mul accepted:**
  - go to MUL.
  - clear the accumulator and load the multiplicand and multiplier.
  - set the counter to WIDTH.
- **MUL state, each cycle:**
  - if multiplier bit 0 is set, add the multiplicand into the accumulator.
  - shift the multiplicand left and the multiplier right.
  - decrement the counter.
  - when the counter reaches 0, latch the product and flags and go to DONE.
- **DONE state:**
  - out_valid is high; alu_out and alu_flags are held stable until out_ready.
  - out_ready low: stay in DONE, holding the outputs.
  - out_ready high with a new request accepted at the same edge: process the new request as from IDLE (back-to-back).
  - out_ready high with no new request: go to IDLE and drop out_valid.
- **Arithmetic:** all operations are unsigned and modulo 2^WIDTH, except mul, which produces the full 2*WIDTH product.
- **Flags:**
  - Z: alu_out == 0, over the full 2*WIDTH bits.
  - N: alu_out[WIDTH-1] for single-cycle ops; alu_out[2W-1] for mul.
  - C, per operation:
    - add: carry out.
    - sub: borrow, i.e. top < bottom.
    - shl: top[WIDTH-1].
    - shr: top[0].
    - mul: upper half nonzero.
    - logic ops: 0.
- **Shift fill:** shl and shr shift by exactly 1 and fill with 0.
- **Reset:**
  - state goes to IDLE.
  - out_valid = 0, alu_out = 0, alu_flags = 0, counter = 0.
  - in_ready = 1 after reset deasserts.
  - reset during MUL or DONE aborts the operation with no output.

## Timing
- **Single-cycle op:** accepted at edge T; out_valid is high after edge T, giving a latency of 1.
- **Mul:** accepted at edge T; out_valid rises after edge T+WIDTH, giving a latency of WIDTH+1 edges. With WIDTH=8, out_valid rises 9 edges after acceptance.
- **Throughput:**
  - single-cycle ops: one per cycle while out_ready stays high.
  - mul: one per WIDTH+1 cycles.
- **Outputs:** all outputs are registered except in_ready, which is combinational from state and out_ready.
- **Held inputs:** in_valid held high while in_ready is low gives no accept, and the operands are not sampled.

## Test plan
- **Add, WIDTH=8:** add 0xFF + 0x01 -> alu_out 0x0000, flags N=0 C=1 Z=1, out_valid one cycle after accept.
- **Sub:** sub 0x03 - 0x05 -> alu_out 0x00FE, N=1 C=1 Z=0. Then xor 0xA5 ^ 0xA5 back-to-back with out_ready high -> 0x0000, Z=1, with no idle cycle between the two results.
- **Mul:** mul 0xFF * 0xFF -> alu_out 0xFE01, N=1 C=1 Z=0. out_valid rises exactly 9 edges after accept; in_ready stays low throughout MUL.
- **Backpressure:** shl 0x81 with out_ready low for 5 cycles -> alu_out held at 0x0002 with C=1, in_ready low, and a pending in_valid not accepted. When out_ready rises, the pending request is accepted at that edge.
- **Reset mid-multiply:** assert reset 4 cycles into mul 0x12 * 0x34 -> out_valid, alu_out and alu_flags immediately 0 and in_ready 1 after release. A following mul 0x12 * 0x34 -> 0x03A8, C=1.
- **Parametrisation:** WIDTH=16, mul 0xFFFF * 0x0002 -> 0x0001FFFE, C=1, latency 17 edges; shr 0x0001 -> 0x00000000, Z=1 C=1.
